// File: rtl/keccak_round_ctrl_if.sv
// Request/completion bus between the sponge wrapper and the Keccak round
// sequencer, plus the strobes and round index that go to the datapath.
//   start, abort, out_ready        : wrapper -> sequencer
//   ready, busy, out_valid         : sequencer -> wrapper
//   load_en, round_en, round       : sequencer -> state register / RC lookup
interface keccak_round_ctrl_if #(
    parameter int ROUND_W = 7
);
    logic               start;
    logic               abort;
    logic               ready;
    logic               busy;
    logic               load_en;
    logic               round_en;
    logic [ROUND_W-1:0] round;
    logic               out_valid;
    logic               out_ready;

    // wrapper side
    modport master (
        output start, abort, out_ready,
        input  ready, busy, load_en, round_en, round, out_valid
    );

    // sequencer side
    modport slave (
        input  start, abort, out_ready,
        output ready, busy, load_en, round_en, round, out_valid
    );
endinterface

// File: rtl/keccak_round_ctrl.sv
// Iterative round sequencer for Keccak-f[1600].
// Walks the round index 0..NUM_ROUNDS-1, spending STAGE_CYCLES clocks per
// round, and strobes load_en / round_en into the state register.
//   clk, rst : clock and synchronous active-high reset
//   bus      : keccak_round_ctrl_if.slave (start/abort/ready/busy,
//              load_en/round_en/round, out_valid/out_ready)
// All outputs are registered; each one is set for the cycle following the
// edge at which the FSM decides it, so the strobes line up with the state.
module keccak_round_ctrl #(
    parameter int NUM_ROUNDS   = 24,
    parameter int ROUND_W      = 7,
    parameter int STAGE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    keccak_round_ctrl_if.slave  bus
);
    localparam int               CNT_W      = $clog2(STAGE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_ROUNDS - 1);
    // With a single-cycle datapath every RUN cycle is an apply cycle, so the
    // strobe must already be armed when entering a round at count 0.
    localparam logic             FIRST_EN   = (STAGE_CYCLES == 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               ready_q;
    logic               busy_q;
    logic               load_en_q;
    logic               round_en_q;
    logic [ROUND_W-1:0] round_q;
    logic               out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            load_en_q   <= 1'b0;
            round_en_q  <= 1'b0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.abort) begin
            // Drop everything; the counter is re-zeroed on the next LOAD.
            state       <= IDLE;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            load_en_q   <= 1'b0;
            round_en_q  <= 1'b0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= LOAD;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        load_en_q <= 1'b1;
                        round_q   <= '0;
                    end
                end
                LOAD: begin
                    state      <= RUN;
                    load_en_q  <= 1'b0;
                    cnt        <= '0;
                    round_en_q <= FIRST_EN;
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (round_q == ROUND_LAST) begin
                            // Last round applied: round stays at the final index.
                            state       <= DONE;
                            round_en_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            round_q    <= round_q + 1'b1;
                            round_en_q <= FIRST_EN;
                        end
                    end else begin
                        cnt        <= cnt + 1'b1;
                        round_en_q <= ((cnt + 1'b1) == CNT_LAST);
                    end
                end
                DONE: begin
                    // start is deliberately ignored here; ready rises first.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        round_q     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.load_en   = load_en_q;
    assign bus.round_en  = round_en_q;
    assign bus.round     = round_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Bench for keccak_round_ctrl: two instances (1 and 3 cycles per round) share
// one stimulus stream and are compared every cycle against a model that
// tracks only "cycles elapsed since start was accepted".
module tb_keccak_round_ctrl;
    localparam int NR = 24;
    localparam int SC [2] = '{1, 3};

    logic clk = 1'b0;
    logic rst_s = 1'b1;
    logic start_s = 1'b0;
    logic abort_s = 1'b0;
    logic out_ready_s = 1'b0;
    bit   chk_on = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    keccak_round_ctrl_if #(.ROUND_W(7)) if0 ();
    keccak_round_ctrl_if #(.ROUND_W(7)) if1 ();

    assign if0.start = start_s;  assign if1.start = start_s;
    assign if0.abort = abort_s;  assign if1.abort = abort_s;
    assign if0.out_ready = out_ready_s;
    assign if1.out_ready = out_ready_s;

    keccak_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_W(7), .STAGE_CYCLES(1))
        dut0 (.clk(clk), .rst(rst_s), .bus(if0));
    keccak_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_W(7), .STAGE_CYCLES(3))
        dut1 (.clk(clk), .rst(rst_s), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: 0 = idle, 1 = permutation in flight (e = cycles since accept), 2 = done.
    int m_mode [2] = '{0, 0};
    int m_e    [2] = '{0, 0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_s || abort_s) m_mode[d] = 0;
            else case (m_mode[d])
                0: if (start_s) begin m_mode[d] = 1; m_e[d] = 1; end
                1: begin
                    m_e[d]++;
                    if (m_e[d] == 2 + NR * SC[d]) m_mode[d] = 2;
                end
                default: if (out_ready_s) m_mode[d] = 0;
            endcase
        end
    end

    task automatic check_dut(input int d, input logic rdy, input logic bsy, input logic ld,
                             input logic ren, input logic [6:0] rnd, input logic ov);
        int er, eb, el, ee, ernd, eov, k;
        er = 0; eb = 0; el = 0; ee = 0; ernd = 0; eov = 0;
        if (m_mode[d] == 0) er = 1;
        else if (m_mode[d] == 1) begin
            eb = 1;
            if (m_e[d] == 1) el = 1;
            else begin
                k    = m_e[d] - 2;
                ernd = k / SC[d];
                ee   = ((k % SC[d]) == SC[d] - 1) ? 1 : 0;
            end
        end else begin
            eov  = 1;
            ernd = NR - 1;
        end
        chk($sformatf("d%0d_ready", d),     32'(rdy), 32'(er));
        chk($sformatf("d%0d_busy", d),      32'(bsy), 32'(eb));
        chk($sformatf("d%0d_load_en", d),   32'(ld),  32'(el));
        chk($sformatf("d%0d_round_en", d),  32'(ren), 32'(ee));
        chk($sformatf("d%0d_round", d),     32'(rnd), 32'(ernd));
        chk($sformatf("d%0d_out_valid", d), 32'(ov),  32'(eov));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check_dut(0, if0.ready, if0.busy, if0.load_en, if0.round_en, if0.round, if0.out_valid);
            check_dut(1, if1.ready, if1.busy, if1.load_en, if1.round_en, if1.round, if1.out_valid);
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_round0(input int r, input string tag);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (if0.busy && if0.round == 7'(r)) found = 1;
            else tick();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (if0.ready && if1.ready) found = 1;
            else tick();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int lat0, lat1;
        // reset
        tick(); chk_on = 1'b1;
        tick();
        chk("rst_ready", 32'(if0.ready), 32'd1);
        chk("rst_round", 32'(if1.round), 32'd0);
        rst_s = 1'b0;
        tick();

        // basic run with immediate consume; measure latencies
        out_ready_s = 1'b1;
        start_s = 1'b1; tick(); start_s = 1'b0;
        chk("lat_load", 32'(if0.load_en), 32'd1);
        lat0 = 0; lat1 = 0;
        for (int c = 2; c < 120 && (lat0 == 0 || lat1 == 0); c++) begin
            tick();
            if (if0.out_valid && lat0 == 0) lat0 = c;
            if (if1.out_valid && lat1 == 0) lat1 = c;
        end
        chk("lat_ov_s1", 32'(lat0), 32'd26);
        chk("lat_ov_s3", 32'(lat1), 32'd74);
        wait_idle("idle1");

        // held in DONE with out_ready low, start pulses ignored
        out_ready_s = 1'b0;
        start_s = 1'b1; tick(); start_s = 1'b0;
        tick(26);
        chk("hold_ov", 32'(if0.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            start_s = i[0];
            tick();
        end
        start_s = 1'b0;
        chk("hold_round", 32'(if0.round), 32'd23);
        tick(40);
        chk("hold_ov_s3", 32'(if1.out_valid), 32'd1);
        start_s = 1'b1; out_ready_s = 1'b1; tick(); start_s = 1'b0;
        wait_idle("idle2");

        // abort at round 10, then a full run
        start_s = 1'b1; tick(); start_s = 1'b0;
        wait_round0(10, "wait_r10");
        abort_s = 1'b1; tick(); abort_s = 1'b0;
        chk("abort_ready", 32'(if0.ready), 32'd1);
        chk("abort_round", 32'(if0.round), 32'd0);
        start_s = 1'b1; tick(); start_s = 1'b0;
        tick(80);
        wait_idle("idle3");

        // reset at round 5
        start_s = 1'b1; tick(); start_s = 1'b0;
        wait_round0(5, "wait_r5");
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        chk("rst_mid_busy", 32'(if0.busy), 32'd0);
        start_s = 1'b1; tick(); start_s = 1'b0;
        tick(80);
        wait_idle("idle4");

        // start+abort together, then start alone
        start_s = 1'b1; abort_s = 1'b1; tick(); abort_s = 1'b0;
        chk("sa_load", 32'(if0.load_en), 32'd0);
        tick(); start_s = 1'b0;
        chk("sa_load2", 32'(if0.load_en), 32'd1);
        tick(80);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            start_s     = ($urandom_range(3) == 0);
            abort_s     = ($urandom_range(63) == 0);
            rst_s       = ($urandom_range(199) == 0);
            out_ready_s = $urandom_range(1) == 1;
            tick();
        end
        rst_s = 1'b0; abort_s = 1'b0; start_s = 1'b0; out_ready_s = 1'b1;
        tick(100);
        wait_idle("idle_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
